// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM state, the stage-enable bundle and the stage count.
package pipe_ctrl_pkg;

  localparam int unsigned N_STAGES = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_FLUSH
  } ctrl_state_t;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_en_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (sync, active-low), i_clr, i_inc, o_q[W].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables,
// stage valid bits, PC redirect load, stall counter, miss timeout.
// Ports: clk, rst_n, hazard_rs1_i, hazard_rs2_i, dmem_stall_i,
// imem_stall_i, redirect_i, en_{f,d,e,m,w}_o, valid_{d,e,m,w}_o,
// pc_load_o, stall_cnt_o[CNT_W], err_timeout_o.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_rs1_i,
  input  logic             hazard_rs2_i,
  input  logic             dmem_stall_i,
  input  logic             imem_stall_i,
  input  logic             redirect_i,
  output logic             en_f_o,
  output logic             en_d_o,
  output logic             en_e_o,
  output logic             en_m_o,
  output logic             en_w_o,
  output logic             valid_d_o,
  output logic             valid_e_o,
  output logic             valid_m_o,
  output logic             valid_w_o,
  output logic             pc_load_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_timeout_o
);

  localparam int TW =
    (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
  localparam logic [TW-1:0] LP_MISS = TW'(MISS_TIMEOUT);
  localparam logic [2:0] LP_FLUSH = 3'(FLUSH_CYCLES);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nx;
  logic [2:0]  r_fcnt;
  logic [2:0]  w_fcnt_nx;
  logic        r_vd, r_ve, r_vm, r_vw;
  logic        w_vd_nx, w_ve_nx, w_vm_nx, w_vw_nx;
  logic        r_err;
  stage_en_t   w_en;
  logic        w_pc_load;

  logic w_r1, w_r2, w_r3, w_r4;
  logic w_hit;
  logic [TW-1:0] w_tmr;

  // One-hot rule selects, highest priority first.
  assign w_r1 = dmem_stall_i & r_vm;
  assign w_r2 = ~w_r1 & (hazard_rs1_i | hazard_rs2_i)
              & r_ve & r_vm;
  assign w_r3 = ~w_r1 & ~w_r2 & redirect_i & r_ve;
  assign w_r4 = ~w_r1 & ~w_r2 & ~w_r3
              & (imem_stall_i | (r_state == ST_FLUSH));

  always_comb begin
    w_en      = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b1};
    w_pc_load = 1'b0;
    w_vd_nx   = 1'b1;
    w_ve_nx   = r_vd;
    w_vm_nx   = r_ve;
    w_vw_nx   = r_vm;
    unique case (1'b1)
      w_r1: begin
        w_en    = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b0, w: 1'b1};
        w_vd_nx = r_vd;
        w_ve_nx = r_ve;
        w_vm_nx = r_vm;
        w_vw_nx = 1'b0;
      end
      w_r2: begin
        w_en    = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b1, w: 1'b1};
        w_vd_nx = r_vd;
        w_ve_nx = r_ve;
        w_vm_nx = 1'b0;
      end
      w_r3: begin
        w_pc_load = 1'b1;
        w_vd_nx   = 1'b0;
        w_ve_nx   = 1'b0;
        w_vm_nx   = 1'b1;
      end
      w_r4: begin
        w_en.f  = 1'b0;
        w_en.d  = 1'b0;
        w_vd_nx = 1'b0;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      w_en      = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b0, w: 1'b0};
      w_pc_load = 1'b0;
    end
  end

  // A miss during FLUSH freezes the flush count rather than
  // abandoning it, so the new-PC fetch window is still honoured.
  always_comb begin
    w_state_nx = r_state;
    w_fcnt_nx  = r_fcnt;
    if (w_r1) begin
      if (r_state == ST_RUN) w_state_nx = ST_MEM_WAIT;
    end else begin
      unique case (r_state)
        ST_MEM_WAIT: w_state_nx = ST_RUN;
        ST_FLUSH: begin
          if (r_fcnt <= 3'd1) begin
            w_state_nx = ST_RUN;
            w_fcnt_nx  = 3'd0;
          end else begin
            w_fcnt_nx  = r_fcnt - 3'd1;
          end
        end
        default: begin
        end
      endcase
      if (w_r3) begin
        w_state_nx = ST_FLUSH;
        w_fcnt_nx  = LP_FLUSH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
      r_vd    <= 1'b0;
      r_ve    <= 1'b0;
      r_vm    <= 1'b0;
      r_vw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_fcnt  <= w_fcnt_nx;
      r_vd    <= w_vd_nx;
      r_ve    <= w_ve_nx;
      r_vm    <= w_vm_nx;
      r_vw    <= w_vw_nx;
      if (w_hit) r_err <= 1'b1;
    end
  end

  // Timer reads k-1 during the k-th MEM_WAIT cycle.
  sat_counter #(.W(TW)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state != ST_MEM_WAIT),
    .i_inc (1'b1),
    .o_q   (w_tmr)
  );

  assign w_hit = (MISS_TIMEOUT != 0)
               && (r_state == ST_MEM_WAIT)
               && (w_tmr == LP_MISS);

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (1'b0),
    .i_inc (~w_en.e),
    .o_q   (stall_cnt_o)
  );

  assign en_f_o        = w_en.f;
  assign en_d_o        = w_en.d;
  assign en_e_o        = w_en.e;
  assign en_m_o        = w_en.m;
  assign en_w_o        = w_en.w;
  assign valid_d_o     = r_vd;
  assign valid_e_o     = r_ve;
  assign valid_m_o     = r_vm;
  assign valid_w_o     = r_vw;
  assign pc_load_o     = w_pc_load;
  assign err_timeout_o = r_err | w_hit;

endmodule
